fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit_if.sv | 22 ++
 rtl/fetch_unit.sv | 168 ++++++++++++++++
 tb/tb_fetch_unit.sv | 339 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_unit_if.sv
// Instruction memory bus between the fetch unit and imem.
// The fetch side masters read/address; memory returns resp/rdata.
interface fetch_unit_if;
  logic        imem_read;
  logic [15:0] imem_address;
  logic        imem_resp;
  logic [15:0] imem_rdata;

  modport master (
    output imem_read,
    output imem_address,
    input  imem_resp,
    input  imem_rdata
  );

  modport slave (
    input  imem_read,
    input  imem_address,
    output imem_resp,
    output imem_rdata
  );
endinterface

// File: rtl/fetch_unit.sv
// Fetch stage: PC, one-entry skid buffer and branch squash of reads in flight.
// Define FETCH_PERF_CNT_EN to add stall_cycles/squash_count counters.
module fetch_unit #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         fetch_en,
  input  logic         load_de,
  input  logic         insert_nop,
  input  logic         br_taken,
  input  logic [15:0]  br_target,
  fetch_unit_if.master imem,
  output logic [15:0]  de_ir,
  output logic [15:0]  de_pc,
  output logic         de_valid
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [15:0]  stall_cycles,
  output logic [15:0]  squash_count
`endif
);

  typedef enum logic {RUN, SQUASH} state_e;

  state_e      state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic [15:0] held_q, held_d;
  logic [15:0] buf_ir_q, buf_ir_d;
  logic [15:0] buf_pc_q, buf_pc_d;
  logic        buf_valid_q, buf_valid_d;
  logic        busy_q, busy_d;
  logic [15:0] de_ir_q, de_ir_d;
  logic [15:0] de_pc_q, de_pc_d;
  logic        de_valid_q, de_valid_d;

  logic        read_c;
  logic [15:0] addr_c;
  logic        accept;
  logic        to_de;
  logic [15:0] pc_inc;

  assign pc_inc = pc_q + 16'd2;

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    held_d      = held_q;
    buf_ir_d    = buf_ir_q;
    buf_pc_d    = buf_pc_q;
    buf_valid_d = buf_valid_q;
    de_ir_d     = de_ir_q;
    de_pc_d     = de_pc_q;
    de_valid_d  = de_valid_q;
    read_c      = 1'b0;
    addr_c      = pc_q;
    to_de       = 1'b0;

    unique case (state_q)
      RUN:    read_c = busy_q | (fetch_en & ~buf_valid_q);
      SQUASH: begin
        read_c = 1'b1;
        addr_c = held_q;
      end
    endcase
    // A read must drop the moment reset is seen, not a cycle later.
    read_c = read_c & ~reset;
    busy_d = read_c & ~imem.imem_resp;

    accept = (state_q == RUN) & read_c
           & imem.imem_resp & ~br_taken;
    if (accept) pc_d = pc_inc;

    if (load_de) begin
      if (insert_nop | br_taken) begin
        de_ir_d    = 16'h0000;
        de_valid_d = 1'b0;
      end else if (buf_valid_q) begin
        de_ir_d     = buf_ir_q;
        de_pc_d     = buf_pc_q;
        de_valid_d  = 1'b1;
        buf_valid_d = 1'b0;
      end else if (accept) begin
        de_ir_d    = imem.imem_rdata;
        de_pc_d    = pc_inc;
        de_valid_d = 1'b1;
        to_de      = 1'b1;
      end else begin
        de_ir_d    = 16'h0000;
        de_valid_d = 1'b0;
      end
    end

    if (accept & ~to_de) begin
      buf_ir_d    = imem.imem_rdata;
      buf_pc_d    = pc_inc;
      buf_valid_d = 1'b1;
    end

    if (br_taken) begin
      pc_d        = br_target;
      buf_valid_d = 1'b0;
      if ((state_q == RUN) & read_c & ~imem.imem_resp) begin
        held_d  = pc_q;
        state_d = SQUASH;
      end
    end

    if ((state_q == SQUASH) & imem.imem_resp) state_d = RUN;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= RUN;
      pc_q        <= RESET_PC;
      held_q      <= RESET_PC;
      buf_ir_q    <= 16'h0000;
      buf_pc_q    <= RESET_PC;
      buf_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      de_ir_q     <= 16'h0000;
      de_pc_q     <= RESET_PC;
      de_valid_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      held_q      <= held_d;
      buf_ir_q    <= buf_ir_d;
      buf_pc_q    <= buf_pc_d;
      buf_valid_q <= buf_valid_d;
      busy_q      <= busy_d;
      de_ir_q     <= de_ir_d;
      de_pc_q     <= de_pc_d;
      de_valid_q  <= de_valid_d;
    end
  end

  assign imem.imem_read    = read_c;
  assign imem.imem_address = addr_c;
  assign de_ir             = de_ir_q;
  assign de_pc             = de_pc_q;
  assign de_valid          = de_valid_q;

`ifdef FETCH_PERF_CNT_EN
  logic [15:0] stall_q;
  logic [15:0] squash_q;
  logic        discard;

  assign discard = imem.imem_resp
                 & ((state_q == SQUASH) | br_taken);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_q  <= 16'h0000;
      squash_q <= 16'h0000;
    end else begin
      if (busy_d & (stall_q != 16'hFFFF))
        stall_q <= stall_q + 16'd1;
      if (discard & (squash_q != 16'hFFFF))
        squash_q <= squash_q + 16'd1;
    end
  end

  assign stall_cycles = stall_q;
  assign squash_count = squash_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios plus a random in-order scoreboard.
// Build with FETCH_PERF_CNT_EN to also exercise the performance counters.
module tb_fetch_unit;
  localparam logic [15:0] RST_PC = 16'h0000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        fetch_en = 1'b0;
  logic        load_de = 1'b0;
  logic        insert_nop = 1'b0;
  logic        br_taken = 1'b0;
  logic [15:0] br_target = 16'h0000;
  logic [15:0] de_ir, de_pc;
  logic        de_valid;
`ifdef FETCH_PERF_CNT_EN
  logic [15:0] stall_cycles, squash_count;
`endif

  fetch_unit_if bus ();

  fetch_unit #(.RESET_PC(RST_PC)) dut (
    .clk(clk), .reset(reset), .fetch_en(fetch_en), .load_de(load_de),
    .insert_nop(insert_nop), .br_taken(br_taken), .br_target(br_target),
    .imem(bus), .de_ir(de_ir), .de_pc(de_pc), .de_valid(de_valid)
`ifdef FETCH_PERF_CNT_EN
    , .stall_cycles(stall_cycles), .squash_count(squash_count)
`endif
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic [15:0] mem [0:255];
  int  wcnt, cur_wait;
  int  fixed_wait = 0;
  bit  rand_wait = 1'b0;

  // Memory: answers after cur_wait cycles of a held request (0 = same cycle).
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      wcnt <= 0;
      cur_wait <= 0;
    end else if (!bus.imem_read || bus.imem_resp) begin
      wcnt <= 0;
      cur_wait <= rand_wait ? int'($urandom_range(0, 3)) : fixed_wait;
    end else begin
      wcnt <= wcnt + 1;
    end
  end
  assign bus.imem_resp  = bus.imem_read && (wcnt == cur_wait);
  assign bus.imem_rdata = bus.imem_resp ? mem[bus.imem_address[8:1]] : 16'hDEAD;

  logic        s_read, s_resp;
  logic [15:0] s_addr;

  function automatic logic [15:0] word_at(input logic [15:0] a);
    return mem[a[8:1]];
  endfunction

  // Drive one cycle from a negedge; sample bus mid-cycle, return at next negedge.
  task automatic tick(input logic fe, input logic ld, input logic nop,
                      input logic br, input logic [15:0] tgt);
    fetch_en = fe; load_de = ld; insert_nop = nop;
    br_taken = br; br_target = tgt;
    #1;
    s_read = bus.imem_read;
    s_addr = bus.imem_address;
    s_resp = bus.imem_resp;
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1; fetch_en = 1'b1; load_de = 1'b1;
    #1;
    checks++;
    if (bus.imem_read !== 1'b0) begin
      errors++; $display("FAIL rst_read got=%b exp=0", bus.imem_read);
    end
    @(posedge clk); #1;
    checks++;
    if ({de_ir, de_pc, de_valid} !== {16'h0000, RST_PC, 1'b0}) begin
      errors++; $display("FAIL rst_de got=%h/%h/%b exp=0000/%h/0", de_ir, de_pc, de_valid, RST_PC);
    end
`ifdef FETCH_PERF_CNT_EN
    checks++;
    if ({stall_cycles, squash_count} !== 32'h0) begin
      errors++; $display("FAIL rst_cnt got=%h/%h exp=0/0", stall_cycles, squash_count);
    end
`endif
    @(negedge clk);
    fetch_en = 1'b0; load_de = 1'b0; reset = 1'b0;
  endtask

  task automatic test_zero_wait();
    tick(1, 1, 0, 0, 16'h0);
    checks++;
    if ({s_read, s_addr, s_resp} !== {1'b1, 16'h0000, 1'b1}) begin
      errors++; $display("FAIL zw_bus got=%b/%h/%b exp=1/0000/1", s_read, s_addr, s_resp);
    end
    checks++;
    if ({de_ir, de_pc, de_valid} !== {16'h1234, 16'h0002, 1'b1}) begin
      errors++; $display("FAIL zw_de got=%h/%h/%b exp=1234/0002/1", de_ir, de_pc, de_valid);
    end
  endtask

  task automatic test_buffer();
    tick(1, 0, 0, 0, 16'h0);
    checks++;
    if ({s_read, s_addr, s_resp} !== {1'b1, 16'h0002, 1'b1}) begin
      errors++; $display("FAIL buf_fetch got=%b/%h/%b exp=1/0002/1", s_read, s_addr, s_resp);
    end
    checks++;
    if (de_ir !== 16'h1234) begin
      errors++; $display("FAIL buf_hold_de got=%h exp=1234", de_ir);
    end
    for (int i = 0; i < 3; i++) begin
      tick(1, (i == 2), 0, 0, 16'h0);
      checks++;
      if (s_read !== 1'b0) begin
        errors++; $display("FAIL buf_full_read cyc=%0d got=%b exp=0", i, s_read);
      end
    end
    checks++;
    if ({de_ir, de_pc, de_valid} !== {16'hABCD, 16'h0004, 1'b1}) begin
      errors++; $display("FAIL buf_drain got=%h/%h/%b exp=abcd/0004/1", de_ir, de_pc, de_valid);
    end
    tick(1, 1, 0, 0, 16'h0);
    checks++;
    if ({s_read, s_addr, de_ir, de_pc} !== {1'b1, 16'h0004, word_at(16'h0004), 16'h0006}) begin
      errors++; $display("FAIL buf_next got=%b/%h/%h/%h exp=1/0004/%h/0006", s_read, s_addr, de_ir, de_pc, word_at(16'h0004));
    end
  endtask

  task automatic test_squash();
    bit found;
    fixed_wait = 3;
    tick(0, 1, 0, 1, 16'h0010);
    checks++;
    if (de_valid !== 1'b0) begin
      errors++; $display("FAIL sq_br_nop got=%b exp=0", de_valid);
    end
    tick(1, 0, 0, 0, 16'h0);
    fixed_wait = 0;
    checks++;
    if ({s_read, s_addr, s_resp} !== {1'b1, 16'h0010, 1'b0}) begin
      errors++; $display("FAIL sq_issue got=%b/%h/%b exp=1/0010/0", s_read, s_addr, s_resp);
    end
    tick(1, 0, 0, 1, 16'h0200);
    found = 1'b0;
    for (int n = 0; n < 8 && !found; n++) begin
      tick(1, 1, 0, 0, 16'h0);
      checks++;
      if ({s_read, s_addr} !== {1'b1, 16'h0010}) begin
        errors++; $display("FAIL sq_hold cyc=%0d got=%b/%h exp=1/0010", n, s_read, s_addr);
      end
      if (s_resp) begin
        found = 1'b1;
        checks++;
        if (de_valid !== 1'b0) begin
          errors++; $display("FAIL sq_discard got=%b exp=0", de_valid);
        end
      end
    end
    checks++;
    if (!found) begin
      errors++; $display("FAIL sq_timeout got=no_resp exp=resp");
    end
    tick(1, 1, 0, 0, 16'h0);
    checks++;
    if ({s_addr, s_resp, de_ir, de_pc, de_valid} !== {16'h0200, 1'b1, word_at(16'h0200), 16'h0202, 1'b1}) begin
      errors++; $display("FAIL sq_target got=%h/%b/%h/%h/%b exp=0200/1/%h/0202/1", s_addr, s_resp, de_ir, de_pc, de_valid, word_at(16'h0200));
    end
`ifdef FETCH_PERF_CNT_EN
    checks++;
    if (squash_count !== 16'd1) begin
      errors++; $display("FAIL sq_cnt got=%0d exp=1", squash_count);
    end
`endif
  endtask

  task automatic test_br_coincident();
    tick(1, 1, 0, 1, 16'h0300);
    checks++;
    if ({s_resp, de_ir, de_valid} !== {1'b1, 16'h0000, 1'b0}) begin
      errors++; $display("FAIL bc_nop got=%b/%h/%b exp=1/0000/0", s_resp, de_ir, de_valid);
    end
    tick(1, 1, 0, 0, 16'h0);
    checks++;
    if ({s_addr, s_resp, de_ir, de_pc} !== {16'h0300, 1'b1, word_at(16'h0300), 16'h0302}) begin
      errors++; $display("FAIL bc_target got=%h/%b/%h/%h exp=0300/1/%h/0302", s_addr, s_resp, de_ir, de_pc, word_at(16'h0300));
    end
`ifdef FETCH_PERF_CNT_EN
    checks++;
    if (squash_count !== 16'd2) begin
      errors++; $display("FAIL bc_cnt got=%0d exp=2", squash_count);
    end
`endif
  endtask

  task automatic test_wrap();
    tick(0, 1, 0, 1, 16'hFFFE);
    tick(1, 1, 0, 0, 16'h0);
    checks++;
    if ({s_addr, de_ir, de_pc, de_valid} !== {16'hFFFE, word_at(16'hFFFE), 16'h0000, 1'b1}) begin
      errors++; $display("FAIL wrap_de got=%h/%h/%h/%b exp=fffe/%h/0000/1", s_addr, de_ir, de_pc, de_valid, word_at(16'hFFFE));
    end
    tick(0, 0, 0, 0, 16'h0);
    checks++;
    if ({s_read, s_addr} !== {1'b0, 16'h0000}) begin
      errors++; $display("FAIL wrap_next got=%b/%h exp=0/0000", s_read, s_addr);
    end
  endtask

  // Scoreboard: responses arrive at consecutive addresses and reach
  // decode in order, each at most one load late.
  task automatic test_random();
    logic [15:0] q_ir[$];
    logic [15:0] q_pc[$];
    logic [15:0] exp_addr, e_ir, e_pc, p_addr;
    logic        p_read, p_resp, fe, ld, nop;
    rand_wait = 1'b1;
    tick(0, 1, 0, 1, 16'h0040);
    exp_addr = 16'h0040;
    p_read = 1'b0; p_resp = 1'b0; p_addr = 16'h0;
    for (int n = 0; n < 1500; n++) begin
      fe  = ($urandom_range(0, 9) < 7);
      ld  = ($urandom_range(0, 9) < 6);
      nop = ($urandom_range(0, 9) == 0);
      tick(fe, ld, nop, 0, 16'h0);
      if (p_read && !p_resp) begin
        checks++;
        if ({s_read, s_addr} !== {1'b1, p_addr}) begin
          errors++; $display("FAIL rnd_stable cyc=%0d got=%b/%h exp=1/%h", n, s_read, s_addr, p_addr);
        end
      end
      if (s_resp) begin
        checks++;
        if (s_addr !== exp_addr) begin
          errors++; $display("FAIL rnd_addr cyc=%0d got=%h exp=%h", n, s_addr, exp_addr);
        end
        e_pc = exp_addr + 16'd2;
        q_ir.push_back(word_at(exp_addr));
        q_pc.push_back(e_pc);
        exp_addr = e_pc;
      end
      if (ld) begin
        checks++;
        if (!nop && q_ir.size() > 0) begin
          e_ir = q_ir.pop_front();
          e_pc = q_pc.pop_front();
          if ({de_ir, de_pc, de_valid} !== {e_ir, e_pc, 1'b1}) begin
            errors++; $display("FAIL rnd_de cyc=%0d got=%h/%h/%b exp=%h/%h/1", n, de_ir, de_pc, de_valid, e_ir, e_pc);
          end
        end else if (de_valid !== 1'b0) begin
          errors++; $display("FAIL rnd_nop cyc=%0d got=%b exp=0", n, de_valid);
        end
      end
      checks++;
      if (q_ir.size() > 1) begin
        errors++; $display("FAIL rnd_depth cyc=%0d got=%0d exp<=1", n, q_ir.size());
      end
      p_read = s_read; p_resp = s_resp; p_addr = s_addr;
    end
    rand_wait = 1'b0;
  endtask

  task automatic test_reset_abandon();
    for (int n = 0; n < 10; n++) begin
      tick(0, 1, 0, 0, 16'h0);
      if (!s_read) break;
    end
    fixed_wait = 3;
    tick(0, 0, 0, 0, 16'h0);
    tick(1, 0, 0, 0, 16'h0);
    checks++;
    if ({s_read, s_resp} !== 2'b10) begin
      errors++; $display("FAIL ra_issue got=%b/%b exp=1/0", s_read, s_resp);
    end
    #1 reset = 1'b1;
    #1;
    checks++;
    if ({bus.imem_read, de_pc, de_valid} !== {1'b0, RST_PC, 1'b0}) begin
      errors++; $display("FAIL ra_reset got=%b/%h/%b exp=0/%h/0", bus.imem_read, de_pc, de_valid, RST_PC);
    end
    fixed_wait = 0;
    @(negedge clk);
    reset = 1'b0;
    tick(1, 1, 0, 0, 16'h0);
    checks++;
    if ({s_addr, s_resp, de_ir, de_pc} !== {RST_PC, 1'b1, 16'h1234, 16'h0002}) begin
      errors++; $display("FAIL ra_restart got=%h/%b/%h/%h exp=0000/1/1234/0002", s_addr, s_resp, de_ir, de_pc);
    end
  endtask

`ifdef FETCH_PERF_CNT_EN
  task automatic test_perf_saturate();
    fixed_wait = 70010;
    tick(0, 0, 0, 0, 16'h0);
    fetch_en = 1'b1;
    repeat (70005) @(posedge clk);
    @(negedge clk);
    checks++;
    if (stall_cycles !== 16'hFFFF) begin
      errors++; $display("FAIL perf_sat got=%h exp=ffff", stall_cycles);
    end
    reset = 1'b1;
    #1;
    checks++;
    if ({stall_cycles, squash_count} !== 32'h0) begin
      errors++; $display("FAIL perf_rst got=%h/%h exp=0/0", stall_cycles, squash_count);
    end
    fixed_wait = 0;
    @(negedge clk);
    fetch_en = 1'b0;
    reset = 1'b0;
  endtask
`endif

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);
    mem[0] = 16'h1234;
    mem[1] = 16'hABCD;
    test_reset();
    test_zero_wait();
    test_buffer();
    test_squash();
    test_br_coincident();
    test_wrap();
    test_random();
    test_reset_abandon();
`ifdef FETCH_PERF_CNT_EN
    test_perf_saturate();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
